// File: rtl/piso_rr_arbiter_pkg.sv
// Shared types and helpers for the piso round-robin arbiter.
// Holds the FSM state encoding, default sizes and a width helper.
package piso_rr_arbiter_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } state_e;

    localparam int unsigned DefNInputs       = 4;
    localparam int unsigned DefDoutWidth     = 64;
    localparam int unsigned DefBeatsPerGrant = 4;

    // clog2 that never returns 0, so a 1-beat grant still gets a 1-bit counter.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                bits = i + 1;
            end
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/piso_rr_arbiter_if.sv
// Lane-side and downstream-side handshake bundle of the piso round-robin arbiter.
// The arbiter takes the slave view; whoever feeds lanes and consumes dout takes the master view.
interface piso_rr_arbiter_if
    import piso_rr_arbiter_pkg::*;
#(
    parameter int unsigned NInputs   = DefNInputs,
    parameter int unsigned DoutWidth = DefDoutWidth
);

    localparam int unsigned SrcW = clog2_min1(NInputs);

    logic [NInputs*DoutWidth-1:0] din;
    logic [NInputs-1:0]           din_valid;
    logic [NInputs-1:0]           din_ready;
    logic [DoutWidth-1:0]         dout;
    logic                         dout_valid;
    logic                         dout_ready;
    logic [SrcW-1:0]              dout_src;
    logic                         dout_last;

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output dout,
        output dout_valid,
        input  dout_ready,
        output dout_src,
        output dout_last
    );

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  dout,
        input  dout_valid,
        output dout_ready,
        input  dout_src,
        input  dout_last
    );

endinterface

// File: rtl/piso_rr_arbiter_rr_priority_pick.sv
// Rotating-priority encoder: picks the first requester strictly after last_grant_i,
// wrapping modulo NInputs, so the previous winner has lowest priority.
module rr_priority_pick #(
    parameter int unsigned NInputs = 4,
    parameter int unsigned IdxW    = 2
) (
    input  logic [NInputs-1:0] req_i,
    input  logic [IdxW-1:0]    last_grant_i,
    output logic [IdxW-1:0]    pick_o,
    output logic               pick_valid_o
);

    logic [IdxW-1:0] idx;

    always_comb begin
        pick_o       = '0;
        pick_valid_o = 1'b0;
        idx          = '0;
        for (int unsigned k = 1; k <= NInputs; k++) begin
            idx = IdxW'((32'(last_grant_i) + k) % NInputs);
            if (!pick_valid_o && req_i[idx]) begin
                pick_valid_o = 1'b1;
                pick_o       = idx;
            end
        end
    end

endmodule

// File: rtl/piso_rr_arbiter.sv
// Round-robin arbiter merging N piso lanes onto one narrow stream; each grant holds for
// BeatsPerGrant accepted beats so one wide word leaves contiguously.
module piso_rr_arbiter
    import piso_rr_arbiter_pkg::*;
#(
    parameter int unsigned NInputs       = DefNInputs,
    parameter int unsigned DoutWidth     = DefDoutWidth,
    parameter int unsigned BeatsPerGrant = DefBeatsPerGrant
) (
    input logic               clk,
    input logic               rst,
    piso_rr_arbiter_if.slave  bus
);

    localparam int unsigned SrcW = clog2_min1(NInputs);
    localparam int unsigned CntW = clog2_min1(BeatsPerGrant);
    localparam logic [CntW-1:0] LastBeat = CntW'(BeatsPerGrant - 1);

    state_e          state_q, state_d;
    logic [SrcW-1:0] grant_q, grant_d;
    logic [SrcW-1:0] last_grant_q, last_grant_d;
    logic [CntW-1:0] beat_q, beat_d;
    logic [SrcW-1:0] pick;
    logic            pick_valid;

    rr_priority_pick #(
        .NInputs (NInputs),
        .IdxW    (SrcW)
    ) u_pick (
        .req_i        (bus.din_valid),
        .last_grant_i (last_grant_q),
        .pick_o       (pick),
        .pick_valid_o (pick_valid)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        beat_d         = beat_q;
        bus.din_ready  = '0;
        bus.dout_valid = 1'b0;
        bus.dout_last  = 1'b0;
        bus.dout       = bus.din[grant_q*DoutWidth +: DoutWidth];
        bus.dout_src   = grant_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick;
                    beat_d  = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                // Zero-latency pass-through; a dropped valid simply stalls the burst.
                bus.dout_valid         = bus.din_valid[grant_q];
                bus.din_ready[grant_q] = bus.dout_ready;
                if (bus.din_valid[grant_q] && bus.dout_ready) begin
                    if (beat_q == LastBeat) begin
                        bus.dout_last = 1'b1;
                        last_grant_d  = grant_q;
                        beat_d        = '0;
                        state_d       = StIdle;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= SrcW'(NInputs - 1);
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
        end
    end

endmodule
